multicycle_main_control: RTL and testbench

- Main control FSM for the multi-cycle variant of the 32-bit RISC datapath.
- Sits upstream of the ALU control unit: decodes opcode, sequences fetch/decode/execute/memory/writeback, and drives ALUOp (00 add, 01 sub, 10 funct-decode) plus all datapath enables/muxes.
- Stalls on a memory ready handshake.

---
 rtl/riscv_ctrl_pkg.sv | 51 +++++
 rtl/imm_src_decoder.sv | 22 ++
 rtl/multicycle_main_control.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC main control.
// Contents:
//   state_t   - control FSM states, FETCH..JAL
//   OP_*      - the opcodes the controller supports
//   ALUOP_*   - ALUOp codes sent to the ALU control unit
//   RES_*, SRCA_*, SRCB_*, IMM_* - datapath mux select encodings
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_decoder.sv
// Immediate format select, decoded combinationally from the opcode.
// Ports:
//   op      in  7  instr[6:0]
//   imm_src out 2  00 I (lw, I-ALU and anything else), 01 S, 10 B, 11 J
module imm_src_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multi-cycle 32-bit RISC datapath. Sequences
// fetch/decode/execute/memory/writeback, drives ALUOp and every datapath
// enable and mux select, and stalls memory states on mem_ready.
// Optional build macro: CTRL_PERF_CNT_EN adds cycle_cnt / instret_cnt.
// Ports:
//   clk, rst       clock (rising edge), synchronous active-high reset
//   op             instr[6:0] from the instruction register
//   zero           ALU zero flag (branch decision)
//   mem_ready      memory finishes the current access this cycle
//   pc_write .. instr_done  datapath controls, see the package encodings
//   state_dbg      current FSM state, for observation only
//   cycle_cnt      (macro) non-reset cycles, wraps
//   instret_cnt    (macro) completed legal instructions, wraps
//
// Handshake: mem_ready is a completion strobe, not a valid/ready pair. The
// controller holds a memory state and its address/strobe outputs until a
// cycle with mem_ready=1; that cycle is the one in which the access retires
// and the FSM advances. mem_ready is ignored in non-memory states.
module multicycle_main_control
  import riscv_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter int         CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state_dbg
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  state_t state, state_next;
  logic   pc_update, branch;

  imm_src_decoder u_imm_src_decoder (
    .op      (op),
    .imm_src (imm_src)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= state_t'(RESET_STATE);
    else     state <= state_next;
  end

  assign state_dbg = state;
  assign pc_write  = pc_update | (branch & zero);

  always_comb begin
    state_next = FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    instr_done = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    if (rst) begin
      // Reset wins over everything: the state register may still hold a
      // mid-instruction state this cycle, so mask strobes and present the
      // FETCH mux settings directly.
      result_src = RES_ALURESULT;
      alu_src_b  = SRCB_FOUR;
    end else begin
      case (state)
        FETCH: begin
          result_src = RES_ALURESULT;
          alu_src_b  = SRCB_FOUR;
          ir_write   = mem_ready;
          pc_update  = mem_ready;
          state_next = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          // Precompute the branch target PC+imm into ALUOut.
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          case (op)
            OP_LW, OP_SW: state_next = MEMADR;
            OP_R:         state_next = EXECR;
            OP_I:         state_next = EXECI;
            OP_BEQ:       state_next = BEQ;
            OP_JAL:       state_next = JAL;
            default: begin
              illegal_op = 1'b1;
              instr_done = 1'b1;
              state_next = FETCH;
            end
          endcase
        end
        MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          if (op == OP_LW)      state_next = MEMREAD;
          else if (op == OP_SW) state_next = MEMWRITE;
          else                  state_next = FETCH;
        end
        MEMREAD: begin
          adr_src    = 1'b1;
          state_next = mem_ready ? MEMWB : MEMREAD;
        end
        MEMWB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        MEMWRITE: begin
          // The write strobe stays up for the whole access; completion is
          // only signalled in the cycle memory accepts it.
          adr_src    = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ready;
          state_next = mem_ready ? FETCH : MEMWRITE;
        end
        EXECR: begin
          alu_src_a  = SRCA_RS1;
          alu_op     = ALUOP_FUNCT;
          state_next = ALUWB;
        end
        EXECI: begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_IMM;
          alu_op     = ALUOP_FUNCT;
          state_next = ALUWB;
        end
        ALUWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        BEQ: begin
          alu_src_a  = SRCA_RS1;
          alu_op     = ALUOP_SUB;
          branch     = 1'b1;
          instr_done = 1'b1;
        end
        JAL: begin
          // PC <= target from DECODE while the ALU forms OldPC+4 for rd.
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_FOUR;
          pc_update  = 1'b1;
          state_next = ALUWB;
        end
        default: state_next = FETCH;
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (instr_done && !illegal_op) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
module tb_multicycle_main_control;

  localparam int W = 17;
  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_BEQ = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = T_LW;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic       illegal_op, instr_done;
  logic [3:0] state_dbg;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
  logic [31:0] exp_cyc = '0, exp_ret = '0;
  logic        cnt_valid = 1'b0;
`endif

  always #5 clk = ~clk;

  multicycle_main_control dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .illegal_op(illegal_op), .instr_done(instr_done),
    .state_dbg(state_dbg)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  wire [W-1:0] outs = {pc_write, adr_src, mem_write, ir_write, reg_write,
                       result_src, alu_src_a, alu_src_b, alu_op, imm_src,
                       illegal_op, instr_done};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         mr_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [6:0]   cur_op = T_LW;
  logic         cur_z = 1'b0;
  logic [1:0]   cur_imm = 2'b00;
  string        tag = "reset";

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == T_SW)  return 2'b01;
    if (o == T_BEQ) return 2'b10;
    if (o == T_JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [W-1:0] v(input logic pcw, adr, mw, irw, rw,
                                     input logic [1:0] rs, a, b, aop,
                                     input logic ill, done);
    return {pcw, adr, mw, irw, rw, rs, a, b, aop, cur_imm, ill, done};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [W-1:0] e, input logic mr);
    exp_q.push_back(e);
    mr_q.push_back(mr);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic mr, input logic [W-1:0] e);
    @(negedge clk);
    rst = r; mem_ready = mr; op = cur_op; zero = cur_z;
    #1;
    n_cmp++;
    assert (outs === e) else begin
      n_err++;
      $error("FAIL %s outs got=%b exp=%b", tag, outs, e);
    end
`ifdef CTRL_PERF_CNT_EN
    if (cnt_valid) begin
      n_cmp++;
      assert (cycle_cnt === exp_cyc) else begin
        n_err++;
        $error("FAIL %s cycle_cnt got=%0d exp=%0d", tag, cycle_cnt, exp_cyc);
      end
      n_cmp++;
      assert (instret_cnt === exp_ret) else begin
        n_err++;
        $error("FAIL %s instret_cnt got=%0d exp=%0d", tag, instret_cnt, exp_ret);
      end
    end
    if (r) begin
      exp_cyc = '0; exp_ret = '0; cnt_valid = 1'b1;
    end else begin
      exp_cyc++;
      if (e[0] && !e[1]) exp_ret++;
    end
`endif
  endtask

  // Expected per-cycle outputs for one instruction, written from the
  // instruction's step list (fs fetch stalls, ms memory stalls).
  task automatic build(input logic [6:0] o, input logic z, input int fs, input int ms);
    logic legal;
    logic [W-1:0] memadr, aluwb;
    cur_op = o; cur_z = z; cur_imm = imm_of(o);
    legal  = (o == T_LW) || (o == T_SW) || (o == T_R) || (o == T_I) ||
             (o == T_BEQ) || (o == T_JAL);
    memadr = v(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 0,0);
    aluwb  = v(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 0,1);
    repeat (fs) push(v(0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 0,0), 1'b0);
    push(v(1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 0,0), 1'b1);
    push(v(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, !legal, !legal), rnd());
    case (o)
      T_LW: begin
        push(memadr, rnd());
        repeat (ms) push(v(0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,0), 1'b0);
        push(v(0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,0), 1'b1);
        push(v(0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00, 0,1), rnd());
      end
      T_SW: begin
        push(memadr, rnd());
        repeat (ms) push(v(0,1,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,0), 1'b0);
        push(v(0,1,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,1), 1'b1);
      end
      T_R: begin
        push(v(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 0,0), rnd());
        push(aluwb, rnd());
      end
      T_I: begin
        push(v(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b10, 0,0), rnd());
        push(aluwb, rnd());
      end
      T_BEQ: push(v(z,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b01, 0,1), rnd());
      T_JAL: begin
        push(v(1,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b00, 0,0), rnd());
        push(aluwb, rnd());
      end
      default: ;
    endcase
  endtask

  task automatic run(input string t);
    tag = t;
    while (exp_q.size() > 0) step(1'b0, mr_q.pop_front(), exp_q.pop_front());
  endtask

  task automatic reset_step();
    cur_imm = imm_of(cur_op);
    step(1'b1, 1'b1, v(0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 0,0));
  endtask

  // ---------------- directed + random sequence ----------------
  logic [6:0] legal_ops[6];
  logic [6:0] ro;

  initial begin
    legal_ops[0] = T_LW; legal_ops[1] = T_SW;  legal_ops[2] = T_R;
    legal_ops[3] = T_I;  legal_ops[4] = T_BEQ; legal_ops[5] = T_JAL;

    tag = "reset";
    reset_step();
    reset_step();

    build(T_LW, 1'b0, 0, 0);        run("lw");
    build(T_SW, 1'b0, 0, 3);        run("sw_stall");
    build(T_BEQ, 1'b1, 0, 0);       run("beq_taken");
    build(T_BEQ, 1'b0, 0, 0);       run("beq_not_taken");
    build(T_R, 1'b1, 0, 0);         run("r_type");
    build(T_JAL, 1'b0, 0, 0);       run("jal");
    build(7'b1111111, 1'b0, 0, 0);  run("illegal");
    build(T_I, 1'b0, 2, 0);         run("i_fetch_stall");
    build(T_LW, 1'b1, 1, 2);        run("lw_stall");

    // Reset while a store is stalled in its write state.
    build(T_SW, 1'b0, 0, 5);
    tag = "sw_pre_reset";
    for (int i = 0; i < 4; i++) step(1'b0, mr_q.pop_front(), exp_q.pop_front());
    exp_q.delete(); mr_q.delete();
    tag = "reset_mid_sw";
    reset_step();
    build(T_R, 1'b0, 0, 0);         run("r_after_reset");

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do ro = 7'($urandom_range(0, 127));
        while (ro inside {T_LW, T_SW, T_R, T_I, T_BEQ, T_JAL});
      end else begin
        ro = legal_ops[$urandom_range(0, 5)];
      end
      build(ro, rnd(), $urandom_range(0, 2), $urandom_range(0, 3));
      run("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
